// File: rtl/three_input_merge_pkg.sv
// Shared types and constants for the 3:1 controlled merge.
package merge_pkg;
    localparam int SEL_W = 2;
    localparam int NUM_IN = 3;
    localparam logic [SEL_W-1:0] SEL_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SEND      = 2'd2
    } merge_state_t;

    // Ready mask for the lane a select token points at; illegal select maps to no lane.
    function automatic logic [NUM_IN-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_IN-1:0] oh;
        oh = '0;
        case (s)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction
endpackage

// File: rtl/three_input_merge_if.sv
// Select/lane/result valid-ready bundle for the 3:1 merge.
interface three_input_merge_if #(parameter int WIDTH = 24);
    import merge_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [SEL_W-1:0]  s_data;
    logic [NUM_IN-1:0] l_valid;
    logic [NUM_IN-1:0] l_ready;
    logic [WIDTH-1:0]  l_data0;
    logic [WIDTH-1:0]  l_data1;
    logic [WIDTH-1:0]  l_data2;
    logic              r_valid;
    logic              r_ready;
    logic [WIDTH-1:0]  r_data;

    modport master (
        output s_valid, s_data, l_valid, l_data0, l_data1, l_data2, r_ready,
        input  s_ready, l_ready, r_valid, r_data
    );

    modport slave (
        input  s_valid, s_data, l_valid, l_data0, l_data1, l_data2, r_ready,
        output s_ready, l_ready, r_valid, r_data
    );
endinterface

// File: rtl/three_input_merge_out_reg.sv
// Valid/ready holding register: loads a word, holds it under backpressure.
module merge_out_reg #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/three_input_merge.sv
// 3:1 controlled merge: select token, then one word from the chosen lane, then output.
// Optional THREE_MERGE_ERR_EN adds a sticky err flag and a saturating illegal-token counter.
module three_input_merge
    import merge_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst,
    three_input_merge_if.slave bus,
    output logic               err
);
    merge_state_t     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NUM_IN-1:0] lane_oh;
    logic             load;
    logic [WIDTH-1:0] mux_data;

    assign lane_oh = sel_onehot(sel_q);

    // Readies depend only on state/sel so no valid input can loop back into them.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        load        = 1'b0;
        bus.s_ready = (state_q == IDLE);
        bus.l_ready = '0;
        case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    sel_d = bus.s_data;
                    if (bus.s_data != SEL_ILLEGAL) state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                bus.l_ready = lane_oh;
                if ((bus.l_valid & lane_oh) != '0) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.r_valid && bus.r_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (sel_q)
            2'd0:    mux_data = bus.l_data0;
            2'd1:    mux_data = bus.l_data1;
            default: mux_data = bus.l_data2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    merge_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (mux_data),
        .ready_i (bus.r_ready),
        .valid_o (bus.r_valid),
        .data_o  (bus.r_data)
    );

`ifdef THREE_MERGE_ERR_EN
    logic       err_q;
    logic [3:0] ill_cnt_q;
    logic       ill_fire;

    assign ill_fire = (state_q == IDLE) && bus.s_valid && (bus.s_data == SEL_ILLEGAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            ill_cnt_q <= '0;
        end else if (ill_fire) begin
            err_q <= 1'b1;
            if (ill_cnt_q != 4'hF) ill_cnt_q <= ill_cnt_q + 4'd1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule
